// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and helpers for fifo_serial_tx.
// FIFO_SERIAL_TX_PARITY_EN adds the PARITY state.
package fifo_serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
`ifdef FIFO_SERIAL_TX_PARITY_EN
    , ST_PARITY
`endif
  } state_t;

  localparam logic TX_IDLE_LEVEL  = 1'b1;
  localparam logic TX_START_LEVEL = 1'b0;

  // Cycles from the falling start edge to the end of the stop bit.
  function automatic int frame_len(input int num_bits, input int clks_per_bit, input bit parity);
    return (2 + num_bits + int'(parity)) * clks_per_bit;
  endfunction

endpackage

// File: rtl/fifo_serial_tx_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, end_of_bit marks the last cycle.
module fifo_serial_tx_baud #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic end_of_bit
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

  logic [BW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= '0;
    else if (clear || cnt == LAST) cnt <= '0;
    else                          cnt <= cnt + BW'(1);
  end

  assign end_of_bit = (cnt == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from a FIFO and sends each as a start/data(LSB first)/stop serial frame.
// FIFO_SERIAL_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int NUM_BITS     = 32,
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_BITS     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                empty,
  input  logic [NUM_BITS-1:0] fifo_data,
  output logic                rd,
  output logic                tx,
  output logic                busy,
  output logic [CNT_BITS-1:0] words_sent
);

  localparam int BCW = $clog2(NUM_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(NUM_BITS - 1);

  state_t              state;
  logic [NUM_BITS-1:0] shift;
  logic [NUM_BITS-1:0] shift_nxt;
  logic [BCW-1:0]      bit_cnt;
  logic                eob;
  logic                start_ok;
  logic                in_load;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic                par;
`endif

  assign start_ok  = en && !empty;
  assign in_load   = (state == ST_LOAD);
  assign shift_nxt = shift >> 1;

  // Clearing during LOAD puts the counter at 0 on the first START cycle.
  fifo_serial_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .rst        (rst),
    .clear      (in_load),
    .end_of_bit (eob)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      tx         <= TX_IDLE_LEVEL;
      rd         <= 1'b0;
      busy       <= 1'b0;
      words_sent <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      rd <= 1'b0;
      case (state)
        ST_IDLE: if (start_ok) begin
          state <= ST_FETCH;
          rd    <= 1'b1;
          busy  <= 1'b1;
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          shift   <= fifo_data;
          bit_cnt <= '0;
          tx      <= TX_START_LEVEL;
          state   <= ST_START;
`ifdef FIFO_SERIAL_TX_PARITY_EN
          par     <= ^fifo_data;
`endif
        end
        ST_START: if (eob) begin
          state <= ST_DATA;
          tx    <= shift[0];
        end
        ST_DATA: if (eob) begin
          shift <= shift_nxt;
          if (bit_cnt == LAST_BIT) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
            state <= ST_PARITY;
            tx    <= par;
`else
            state <= ST_STOP;
            tx    <= TX_IDLE_LEVEL;
`endif
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
            tx      <= shift_nxt[0];
          end
        end
`ifdef FIFO_SERIAL_TX_PARITY_EN
        ST_PARITY: if (eob) begin
          state <= ST_STOP;
          tx    <= TX_IDLE_LEVEL;
        end
`endif
        ST_STOP: if (eob) begin
          words_sent <= words_sent + CNT_BITS'(1);
          if (start_ok) begin
            state <= ST_FETCH;
            rd    <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
